spi_std_master: RTL

- Single-clock SPI master. It is the initiator end of the team's standard slave SPI link.
- Serialises one LEN_SPI-bit word per transaction on MOSI, LSB first, and captures the slave's MISO word in parallel.
- Sits between the chip-side FSM (parallel start/done handshake) and the pads that drive an spi_std_slave instance on another die or FPGA.
- Link format: SCK and CS_N idle high. MOSI changes after SCK rises and is sampled by the slave on SCK falling. MISO is sampled by the master at SCK falling.

---
 rtl/spi_std_master.sv | 131 +++++++++++++
 1 files changed

// File: rtl/spi_std_master.sv
// SPI master, mode with SCK/CS_N idling high: MOSI changes on SCK rise, MISO captured on SCK fall.
// One LEN_SPI-bit word per transaction, LSB first, with parallel start/done handshake.
module spi_std_master #(
  parameter int LEN_SPI      = 32,
  parameter int BITS_CNT_SPI = 6,
  parameter int CLK_DIV      = 4,
  parameter int CS_SETUP     = 2,
  parameter int CS_HOLD      = 2,
  parameter int CS_GAP       = 4,
  parameter int TMR_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_SPI-1:0] tx_data,
  output logic [LEN_SPI-1:0] rx_data,
  output logic               busy,
  output logic               done,
  output logic               sck,
  output logic               cs_n,
  output logic               mosi,
  input  logic               miso
);

  localparam logic [TMR_W-1:0] SETUP_END = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0] DIV_END   = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] HOLD_END  = TMR_W'(CS_HOLD - 1);
  localparam logic [TMR_W-1:0] GAP_END   = TMR_W'(CS_GAP - 1);
  localparam logic [BITS_CNT_SPI-1:0] LAST_BIT = BITS_CNT_SPI'(LEN_SPI - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

  state_t                  state, state_next;
  logic [TMR_W-1:0]        timer;
  logic [BITS_CNT_SPI-1:0] bit_cnt;
  logic [LEN_SPI-2:0]      tx_rest;
  logic [LEN_SPI-1:0]      rx_shift;
  logic                    phase_end;
  logic                    last_bit;

  assign last_bit = (bit_cnt == LAST_BIT);

  always_comb begin
    phase_end  = 1'b0;
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = SETUP;
      SETUP: begin
        phase_end = (timer == SETUP_END);
        if (phase_end) state_next = LOW;
      end
      LOW: begin
        phase_end = (timer == DIV_END);
        if (phase_end) state_next = last_bit ? HOLD : HIGH;
      end
      HIGH: begin
        phase_end = (timer == DIV_END);
        if (phase_end) state_next = LOW;
      end
      HOLD: begin
        phase_end = (timer == HOLD_END);
        if (phase_end) state_next = GAP;
      end
      GAP: begin
        phase_end = (timer == GAP_END);
        if (phase_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The phase timer restarts from zero whenever the state changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || state == IDLE) timer <= '0;
      else                                      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck      <= 1'b1;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      rx_shift <= '0;
      tx_rest  <= '0;
      bit_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          // Bit 0 goes straight to the pad; only the remaining bits are kept.
          tx_rest  <= tx_data[LEN_SPI-1:1];
          mosi     <= tx_data[0];
          rx_shift <= '0;
          bit_cnt  <= '0;
          cs_n     <= 1'b0;
          busy     <= 1'b1;
        end
        SETUP, HIGH: if (phase_end) begin
          sck      <= 1'b0;
          rx_shift <= {miso, rx_shift[LEN_SPI-1:1]};
        end
        LOW: if (phase_end) begin
          sck <= 1'b1;
          if (!last_bit) begin
            bit_cnt <= bit_cnt + 1'b1;
            mosi    <= tx_rest[0];
            tx_rest <= tx_rest >> 1;
          end
        end
        HOLD: if (phase_end) begin
          cs_n    <= 1'b1;
          mosi    <= 1'b0;
          rx_data <= rx_shift;
          done    <= 1'b1;
        end
        GAP: if (phase_end) busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
